// File: rtl/counter_sched_pkg.sv
// Shared types for the round-robin counter scheduler: opcode encoding and default counter width.
package counter_sched_pkg;

  localparam int CW_DEFAULT = 32;

  typedef enum logic [1:0] {
    INC   = 2'd0,
    DEC   = 2'd1,
    LOAD  = 2'd2,
    CLEAR = 2'd3
  } op_e;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Round-robin arbiter: combinational pick from rr_ptr, registered one-hot gnt.
// Latency: req to gnt 1 cycle; a requester holding req is granted within NREQ cycles.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            pick_vld,
  output logic [PW-1:0]   pick_idx
);

  logic [PW-1:0] rr_ptr;

  // pick_vld/pick_idx describe the grant that lands on the coming edge
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      gnt <= '0;
      if (pick_vld) begin
        gnt[pick_idx] <= 1'b1;
        rr_ptr        <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shared counter with round-robin access; saturating INC/DEC when COUNTER_SCHED_SAT_EN is defined.
// Latency: req to gnt/count/ovf update 1 cycle; requesters hold req/op/wdata until granted.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int            NREQ    = 4,
  parameter int            CW      = CW_DEFAULT,
  parameter logic [CW-1:0] RST_VAL = '0,
  localparam int           PW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  op,
  input  logic [CW*NREQ-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [CW-1:0]      count,
  output logic               busy,
  output logic               ovf
);

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  op_e           cur_op;
  logic [CW-1:0] cur_wdata;
  logic [CW-1:0] count_nxt;
  logic          ovf_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );

  assign busy = |req;

  always_comb begin
    cur_op    = op_e'(op[2*int'(pick_idx) +: 2]);
    cur_wdata = wdata[CW*int'(pick_idx) +: CW];
    count_nxt = count;
    ovf_nxt   = 1'b0;
    if (pick_vld) begin
      unique case (cur_op)
        INC: begin
          if (&count) begin
            ovf_nxt = 1'b1;
`ifdef COUNTER_SCHED_SAT_EN
            count_nxt = count;
`else
            count_nxt = '0;
`endif
          end else begin
            count_nxt = count + 1'b1;
          end
        end
        DEC: begin
          if (count == '0) begin
            ovf_nxt = 1'b1;
`ifdef COUNTER_SCHED_SAT_EN
            count_nxt = count;
`else
            count_nxt = '1;
`endif
          end else begin
            count_nxt = count - 1'b1;
          end
        end
        LOAD:  count_nxt = cur_wdata;
        CLEAR: count_nxt = RST_VAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched (NREQ=4, CW=32); expectations follow COUNTER_SCHED_SAT_EN.
module tb_counter_sched;
  import counter_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [2*NREQ-1:0]  op;
  logic [CW*NREQ-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [CW-1:0]      count;
  logic               busy;
  logic               ovf;

  int checks = 0;
  int errors = 0;

  counter_sched #(.NREQ(NREQ), .CW(CW), .RST_VAL('0)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .wdata (wdata),
    .gnt   (gnt),
    .count (count),
    .busy  (busy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle before sampling or driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] exp_cnt;
    rst   = 1'b1;
    req   = '0;
    op    = '0;
    wdata = '0;

    // reset then idle
    step();
    step();
    check("rst_count", count, 0);
    check("rst_gnt", gnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("idle_count", count, 0);
      check("idle_gnt", gnt, 0);
      check("idle_ovf", ovf, 0);
      check("idle_busy", busy, 0);
    end

    // single requester streaming INC
    req     = 4'b0001;
    op[1:0] = INC;
    #1 check("single_busy", busy, 1);
    for (int c = 1; c <= 10; c++) begin
      step();
      check("single_gnt", gnt, 4'b0001);
      check("single_count", count, c);
      check("single_ovf", ovf, 0);
    end
    req = '0;
    step();
    check("single_release_gnt", gnt, 0);
    check("single_hold_count", count, 10);

    // round robin, all INC
    do_reset();
    op  = {INC, INC, INC, INC};
    req = 4'b1111;
    begin
      logic [NREQ-1:0] rr_seq [5];
      rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int c = 0; c < 5; c++) begin
        step();
        check("rr_gnt", gnt, rr_seq[c]);
        check("rr_count", count, c + 1);
      end
    end
    req = '0;
    step();

    // load all-ones then INC wraps (or saturates)
    do_reset();
    req             = 4'b0100;
    op[5:4]         = LOAD;
    wdata[95:64]    = 32'hFFFF_FFFF;
    step();
    check("load_gnt", gnt, 4'b0100);
    check("load_count", count, 32'hFFFF_FFFF);
    check("load_ovf", ovf, 0);
    op[5:4] = INC;
    step();
`ifdef COUNTER_SCHED_SAT_EN
    exp_cnt = 32'hFFFF_FFFF;
`else
    exp_cnt = 32'h0;
`endif
    check("inc_wrap_gnt", gnt, 4'b0100);
    check("inc_wrap_count", count, exp_cnt);
    check("inc_wrap_ovf", ovf, 1);
    req = '0;
    step();
    check("inc_wrap_ovf_pulse", ovf, 0);
    check("inc_wrap_idle_gnt", gnt, 0);

    // DEC at 0 from req1 and CLEAR from req3 raised together
    do_reset();
    op[3:2] = DEC;
    op[7:6] = CLEAR;
    req     = 4'b1010;
    step();
`ifdef COUNTER_SCHED_SAT_EN
    exp_cnt = 32'h0;
`else
    exp_cnt = 32'hFFFF_FFFF;
`endif
    check("mix_dec_gnt", gnt, 4'b0010);
    check("mix_dec_count", count, exp_cnt);
    check("mix_dec_ovf", ovf, 1);
    req = 4'b1000;
    step();
    check("mix_clr_gnt", gnt, 4'b1000);
    check("mix_clr_count", count, 0);
    check("mix_clr_ovf", ovf, 0);
    req = '0;
    step();

    // plain DEC without wrap: load 5 then DEC
    op[1:0]     = LOAD;
    wdata[31:0] = 32'd5;
    req         = 4'b0001;
    step();
    check("pre_dec_count", count, 5);
    op[1:0] = DEC;
    step();
    check("dec_count", count, 4);
    check("dec_ovf", ovf, 0);

    // reload 5, then reset in the same cycle an INC is presented
    op[1:0] = LOAD;
    step();
    check("pre_rst_count", count, 5);
    op[1:0] = INC;
    rst     = 1'b1;
    step();
    check("midrst_count", count, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_ovf", ovf, 0);
    // rr_ptr back at 0 means req0 beats req3
    rst     = 1'b0;
    op[7:6] = INC;
    req     = 4'b1001;
    step();
    check("midrst_ptr_gnt", gnt, 4'b0001);
    check("midrst_ptr_count", count, 1);
    req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
